// File: rtl/alu_seq_pkg.sv
// Shared constants, state encoding and instruction decode for the ALU op sequencer.
package alu_seq_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned REG_AW  = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXEC   = 2'd1,
        RETIRE = 2'd2
    } state_t;

    typedef struct packed {
        logic [2:0]        op;
        logic [REG_AW-1:0] dest;
        logic              wb;
        logic              beq;
        logic              illegal;
        logic              use_imm;
    } decode_t;

    // Undecodable encodings fall through as an AND with no writeback.
    function automatic decode_t decode(input logic [INSTR_W-1:0] ins);
        decode_t d;
        d.op      = ALU_AND;
        d.dest    = ins[15:11];
        d.wb      = 1'b0;
        d.beq     = 1'b0;
        d.illegal = 1'b1;
        d.use_imm = 1'b0;
        case (ins[31:26])
            OP_RTYPE: begin
                d.wb      = 1'b1;
                d.illegal = 1'b0;
                case (ins[5:0])
                    FN_ADD:  d.op = ALU_ADD;
                    FN_SUB:  d.op = ALU_SUB;
                    FN_AND:  d.op = ALU_AND;
                    FN_OR:   d.op = ALU_OR;
                    FN_SLT:  d.op = ALU_SLT;
                    default: begin
                        d.wb      = 1'b0;
                        d.illegal = 1'b1;
                    end
                endcase
            end
            OP_ADDI: begin
                d.op      = ALU_ADD;
                d.dest    = ins[20:16];
                d.wb      = 1'b1;
                d.illegal = 1'b0;
                d.use_imm = 1'b1;
            end
            OP_BEQ: begin
                d.op      = ALU_SUB;
                d.beq     = 1'b1;
                d.illegal = 1'b0;
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// Register file: three combinational read ports, one synchronous write port, r0 hardwired to zero.
module alu_seq_regfile
    import alu_seq_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREG   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] rs_addr,
    output logic [DATA_W-1:0] rs_data,
    input  logic [REG_AW-1:0] rt_addr,
    output logic [DATA_W-1:0] rt_data,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs [NREG];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rs_data  = (rs_addr  == '0) ? '0 : regs[rs_addr];
    assign rt_data  = (rt_addr  == '0) ? '0 : regs[rt_addr];
    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/alu_op_sequencer.sv
// Three-state sequencer: accept and decode an instruction, drive the external ALU, retire its result.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREG   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [2:0]         alu_op,
    input  logic [DATA_W-1:0]  alu_z,
    input  logic               alu_zero,
    output logic               done,
    output logic               branch_taken,
    output logic               illegal,
    output logic [DATA_W-1:0]  result,
    input  logic [REG_AW-1:0]  dbg_addr,
    output logic [DATA_W-1:0]  dbg_data
);

    state_t            state;
    decode_t           dec_c;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm_ext;
    logic [REG_AW-1:0] dest_q;
    logic              wb_q;
    logic              beq_q;
    logic              ill_q;

    assign dec_c       = decode(instr);
    assign imm_ext     = {{(DATA_W-16){instr[15]}}, instr[15:0]};
    assign instr_ready = (state == IDLE);

    alu_seq_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .we       ((state == EXEC) && wb_q),
        .waddr    (dest_q),
        .wdata    (alu_z),
        .rs_addr  (instr[25:21]),
        .rs_data  (rs_data),
        .rt_addr  (instr[20:16]),
        .rt_data  (rt_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Operands are latched at accept so instr is free to change afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op       <= '0;
            dest_q       <= '0;
            wb_q         <= 1'b0;
            beq_q        <= 1'b0;
            ill_q        <= 1'b0;
            result       <= '0;
            done         <= 1'b0;
            branch_taken <= 1'b0;
            illegal      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        alu_a  <= rs_data;
                        alu_b  <= dec_c.use_imm ? imm_ext : rt_data;
                        alu_op <= dec_c.op;
                        dest_q <= dec_c.dest;
                        wb_q   <= dec_c.wb;
                        beq_q  <= dec_c.beq;
                        ill_q  <= dec_c.illegal;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    result       <= alu_z;
                    branch_taken <= beq_q && alu_zero;
                    illegal      <= ill_q;
                    done         <= 1'b1;
                    state        <= RETIRE;
                end
                RETIRE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU attached to its operand ports.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_z;
    logic        alu_zero;
    logic        done;
    logic        branch_taken;
    logic        illegal;
    logic [31:0] result;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int pass_cnt = 0;
    int total    = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_z        (alu_z),
        .alu_zero     (alu_zero),
        .done         (done),
        .branch_taken (branch_taken),
        .illegal      (illegal),
        .result       (result),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    // Reference 32-bit ALU
    always_comb begin
        case (alu_op)
            3'b000:  alu_z = alu_a & alu_b;
            3'b001:  alu_z = alu_a | alu_b;
            3'b010:  alu_z = alu_a + alu_b;
            3'b110:  alu_z = alu_a - alu_b;
            3'b111:  alu_z = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default: alu_z = 32'd0;
        endcase
        alu_zero = (alu_z == 32'd0);
    end

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic read_reg(input logic [4:0] a, output logic [31:0] d);
        dbg_addr = a;
        #1;
        d = dbg_data;
    endtask

    // Issue one instruction from IDLE and follow it to retirement.
    task automatic issue(input logic [31:0] ins, output logic [31:0] res,
                         output logic tk, output logic il);
        int lat;
        @(negedge clk);
        instr       = ins;
        instr_valid = 1'b1;
        check("ready_before_accept", 32'(instr_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = 32'hDEADBEEF;
        check("ready_in_exec", 32'(instr_ready), 32'd0);
        lat = 1;
        while (done !== 1'b1 && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check("done_latency", 32'(lat), 32'd2);
        check("ready_in_retire", 32'(instr_ready), 32'd0);
        res = result;
        tk  = branch_taken;
        il  = illegal;
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("ready_after_retire", 32'(instr_ready), 32'd1);
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [31:0] exp_res;
        logic        exp_taken;
        logic        exp_ill;
        logic [4:0]  reg_addr;
        logic [31:0] exp_reg;
    } vec_t;

    vec_t        vecs [16];
    logic [31:0] exp_regs [32];
    logic [31:0] bb [4];
    int          acc_cyc [4];

    initial begin
        logic [31:0] res, rd;
        logic        tk, il;
        int          k, cyc, dc0;

        vecs[0]  = '{32'h20010005,                    32'd5,        1'b0, 1'b0, 5'd1,  32'd5};
        vecs[1]  = '{enc_i(6'h08, 5'd0, 5'd1, 16'd7), 32'd7,        1'b0, 1'b0, 5'd1,  32'd7};
        vecs[2]  = '{enc_i(6'h08, 5'd0, 5'd2, 16'd9), 32'd9,        1'b0, 1'b0, 5'd2,  32'd9};
        vecs[3]  = '{enc_r(5'd1, 5'd2, 5'd3, 6'h22),  32'hFFFFFFFE, 1'b0, 1'b0, 5'd3,  32'hFFFFFFFE};
        vecs[4]  = '{enc_r(5'd1, 5'd2, 5'd4, 6'h2A),  32'd1,        1'b0, 1'b0, 5'd4,  32'd1};
        vecs[5]  = '{enc_i(6'h04, 5'd1, 5'd1, 16'h10), 32'd0,       1'b1, 1'b0, 5'd1,  32'd7};
        vecs[6]  = '{enc_i(6'h04, 5'd1, 5'd2, 16'h10), 32'hFFFFFFFE, 1'b0, 1'b0, 5'd2, 32'd9};
        vecs[7]  = '{enc_i(6'h08, 5'd0, 5'd0, 16'd3), 32'd3,        1'b0, 1'b0, 5'd0,  32'd0};
        vecs[8]  = '{enc_i(6'h3F, 5'd1, 5'd2, 16'h1800), 32'd1,     1'b0, 1'b1, 5'd3,  32'hFFFFFFFE};
        vecs[9]  = '{enc_r(5'd1, 5'd2, 5'd15, 6'h21), 32'd1,        1'b0, 1'b1, 5'd15, 32'd0};
        vecs[10] = '{enc_r(5'd1, 5'd2, 5'd5, 6'h24),  32'd1,        1'b0, 1'b0, 5'd5,  32'd1};
        vecs[11] = '{enc_r(5'd1, 5'd2, 5'd11, 6'h25), 32'd15,       1'b0, 1'b0, 5'd11, 32'd15};
        vecs[12] = '{enc_r(5'd1, 5'd2, 5'd12, 6'h20), 32'd16,       1'b0, 1'b0, 5'd12, 32'd16};
        vecs[13] = '{enc_r(5'd2, 5'd1, 5'd13, 6'h2A), 32'd0,        1'b0, 1'b0, 5'd13, 32'd0};
        vecs[14] = '{enc_i(6'h08, 5'd1, 5'd14, 16'hFFF8), 32'hFFFFFFFF, 1'b0, 1'b0, 5'd14, 32'hFFFFFFFF};
        vecs[15] = '{enc_r(5'd14, 5'd1, 5'd16, 6'h2A), 32'd1,       1'b0, 1'b0, 5'd16, 32'd1};

        for (int i = 0; i < 32; i++) exp_regs[i] = 32'd0;
        exp_regs[1] = 32'd7;   exp_regs[2] = 32'd9;   exp_regs[3] = 32'hFFFFFFFE;
        exp_regs[4] = 32'd1;   exp_regs[5] = 32'd1;   exp_regs[11] = 32'd15;
        exp_regs[12] = 32'd16; exp_regs[14] = 32'hFFFFFFFF; exp_regs[16] = 32'd1;

        // Reset state
        reset = 1'b1; instr_valid = 1'b0; instr = 32'd0; dbg_addr = 5'd0;
        #1;
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        #1;
        check("ready_after_reset", 32'(instr_ready), 32'd1);

        // Table-driven directed vectors
        for (int i = 0; i < 16; i++) begin
            issue(vecs[i].ins, res, tk, il);
            check($sformatf("v%0d_result", i), res, vecs[i].exp_res);
            check($sformatf("v%0d_taken", i), 32'(tk), 32'(vecs[i].exp_taken));
            check($sformatf("v%0d_illegal", i), 32'(il), 32'(vecs[i].exp_ill));
            read_reg(vecs[i].reg_addr, rd);
            check($sformatf("v%0d_reg%0d", i, vecs[i].reg_addr), rd, vecs[i].exp_reg);
        end

        for (int r = 0; r < 32; r++) begin
            read_reg(5'(r), rd);
            check($sformatf("sweep_r%0d", r), rd, exp_regs[r]);
        end

        // Back-to-back with valid held high; garbage offered whenever not ready
        bb[0] = enc_i(6'h08, 5'd0, 5'd6, 16'd1);
        bb[1] = enc_i(6'h08, 5'd6, 5'd7, 16'd2);
        bb[2] = enc_r(5'd6, 5'd7, 5'd8, 6'h20);
        bb[3] = enc_r(5'd7, 5'd8, 5'd9, 6'h25);
        dc0 = done_cnt;
        k = 0;
        @(negedge clk);
        instr_valid = 1'b1;
        for (cyc = 0; cyc < 40 && k < 4; cyc++) begin
            if (instr_ready) begin
                instr = bb[k];
                acc_cyc[k] = cyc;
                k++;
            end else begin
                instr = enc_i(6'h08, 5'd0, 5'd10, 16'h55);
            end
            @(negedge clk);
        end
        instr_valid = 1'b0;
        instr = 32'd0;
        check("b2b_accepts", 32'(k), 32'd4);
        for (int j = 1; j < 4; j++)
            check($sformatf("b2b_spacing%0d", j), 32'(acc_cyc[j] - acc_cyc[j-1]), 32'd3);
        repeat (4) @(negedge clk);
        check("b2b_done_count", 32'(done_cnt - dc0), 32'd4);
        read_reg(5'd6, rd);  check("b2b_r6", rd, 32'd1);
        read_reg(5'd7, rd);  check("b2b_r7", rd, 32'd3);
        read_reg(5'd8, rd);  check("b2b_r8", rd, 32'd4);
        read_reg(5'd9, rd);  check("b2b_r9", rd, 32'd7);
        read_reg(5'd10, rd); check("b2b_r10_untouched", rd, 32'd0);

        // Asynchronous reset in the middle of EXEC
        @(negedge clk);
        instr = enc_r(5'd1, 5'd2, 5'd5, 6'h20);
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        check("mid_exec_alu_a", alu_a, 32'd7);
        dc0 = done_cnt;
        #2 reset = 1'b1;
        #1;
        check("arst_alu_a", alu_a, 32'd0);
        check("arst_alu_b", alu_b, 32'd0);
        check("arst_alu_op", 32'(alu_op), 32'd0);
        check("arst_result", result, 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_taken", 32'(branch_taken), 32'd0);
        check("arst_illegal", 32'(illegal), 32'd0);
        read_reg(5'd1, rd); check("arst_r1_cleared", rd, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("arst_ready_after", 32'(instr_ready), 32'd1);
        repeat (3) @(negedge clk);
        check("arst_no_done", 32'(done_cnt - dc0), 32'd0);
        read_reg(5'd5, rd); check("arst_r5", rd, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
